// File: rtl/hook_reel.sv
// rtl/hook_reel.sv - hook launch/retract controller driven by the swing's trig values
// Optional HOOK_REEL_WEIGHT_EN: loaded retract step shrinks with the grabbed object's weight.
module hook_reel #(
   parameter int OFFSET_X     = 320,
   parameter int OFFSET_Y     = 96,
   parameter int MIN_LENGTH   = 100,
   parameter int MAX_LENGTH   = 600,
   parameter int EXTEND_STEP  = 4,
   parameter int RETRACT_STEP = 4,
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        fire,
   input  logic [7:0]  sinMag,
   input  logic [7:0]  cosMag,
   input  logic        sinNeg,
   input  logic        cosNeg,
   input  logic        hit,
   input  logic [1:0]  hitWeight,
   output logic [10:0] tipX,
   output logic [10:0] tipY,
   output logic        swingEnable,
   output logic        busy,
   output logic        loaded,
   output logic        delivered,
   output logic [1:0]  deliveredWeight
);
   localparam logic [9:0]         MIN_L  = 10'(MIN_LENGTH);
   localparam logic [9:0]         MAX_L  = 10'(MAX_LENGTH);
   localparam logic [9:0]         EXT_S  = 10'(EXTEND_STEP);
   localparam logic [9:0]         RET_S  = 10'(RETRACT_STEP);
   localparam logic signed [11:0] ORG_X  = 12'(OFFSET_X);
   localparam logic signed [11:0] ORG_Y  = 12'(OFFSET_Y);
   localparam logic signed [11:0] LIM_X  = 12'(SCREEN_W);
   localparam logic signed [11:0] LIM_Y  = 12'(SCREEN_H);
   localparam logic signed [11:0] REST_Y = 12'(OFFSET_Y + MIN_LENGTH);

   typedef enum logic [1:0] {IDLE, EXTEND, RETRACT, DELIVER} state_t;

   state_t             state_q, state_d;
   logic [9:0]         length_q, length_d;
   logic [7:0]         sin_mag_q, cos_mag_q;
   logic               sin_neg_q, cos_neg_q;
   logic               latch_en;
   logic               loaded_q, loaded_d;
   logic [1:0]         weight_q, weight_d;
   logic               delivered_q;
   logic [1:0]         delivered_weight_q, delivered_weight_d;
   logic               swing_en_q, busy_q;
   logic [10:0]        tip_x_q, tip_y_q;

   logic [7:0]         src_sin_mag, src_cos_mag;
   logic               src_sin_neg, src_cos_neg;
   logic [9:0]         src_len;
   logic signed [11:0] tip_x_d, tip_y_d;
   logic [9:0]         cand_len;
   logic signed [11:0] cand_x, cand_y;
   logic               cand_out;
   logic [9:0]         ret_step, ret_len;

   function automatic logic signed [11:0] ray_off(input logic [9:0] len, input logic [7:0] mag);
      logic [17:0] prod;
      prod = 18'(len) * 18'(mag);
      return signed'(12'(prod >> 8));
   endfunction

   // IDLE follows the live swing at rest length; every other state uses the ray frozen at launch
   always_comb begin
      src_len     = length_q;
      src_sin_mag = sin_mag_q;
      src_cos_mag = cos_mag_q;
      src_sin_neg = sin_neg_q;
      src_cos_neg = cos_neg_q;
      if (state_q == IDLE) begin
         src_len     = MIN_L;
         src_sin_mag = sinMag;
         src_cos_mag = cosMag;
         src_sin_neg = sinNeg;
         src_cos_neg = cosNeg;
      end
   end

   assign tip_x_d = src_cos_neg ? ORG_X - ray_off(src_len, src_cos_mag)
                                : ORG_X + ray_off(src_len, src_cos_mag);
   assign tip_y_d = src_sin_neg ? ORG_Y + ray_off(src_len, src_sin_mag)
                                : ORG_Y - ray_off(src_len, src_sin_mag);

   assign cand_len = length_q + EXT_S;
   assign cand_x   = cos_neg_q ? ORG_X - ray_off(cand_len, cos_mag_q)
                               : ORG_X + ray_off(cand_len, cos_mag_q);
   assign cand_y   = sin_neg_q ? ORG_Y + ray_off(cand_len, sin_mag_q)
                               : ORG_Y - ray_off(cand_len, sin_mag_q);
   assign cand_out = (cand_len > MAX_L) || cand_x[11] || (cand_x >= LIM_X)
                     || cand_y[11] || (cand_y >= LIM_Y);

`ifdef HOOK_REEL_WEIGHT_EN
   logic [9:0] scaled_step;
   assign scaled_step = RET_S >> weight_q;
   assign ret_step    = !loaded_q ? RET_S : ((scaled_step == 10'd0) ? 10'd1 : scaled_step);
`else
   assign ret_step    = RET_S;
`endif

   assign ret_len = (length_q >= MIN_L + ret_step) ? length_q - ret_step : MIN_L;

   always_comb begin
      state_d            = state_q;
      length_d           = length_q;
      loaded_d           = loaded_q;
      weight_d           = weight_q;
      delivered_weight_d = delivered_weight_q;
      latch_en           = 1'b0;
      case (state_q)
         IDLE: begin
            length_d = MIN_L;
            if (fire) begin
               latch_en = 1'b1;
               state_d  = EXTEND;
            end
         end
         EXTEND: begin
            // a grab outranks a boundary stop seen on the same frame edge
            if (hit) begin
               loaded_d = 1'b1;
               weight_d = hitWeight;
               state_d  = RETRACT;
            end else if (startOfFrame) begin
               if (cand_out) state_d  = RETRACT;
               else          length_d = cand_len;
            end
         end
         RETRACT: begin
            if (startOfFrame) begin
               length_d = ret_len;
               if (ret_len == MIN_L) begin
                  if (loaded_q) begin
                     state_d            = DELIVER;
                     delivered_weight_d = weight_q;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         DELIVER: begin
            loaded_d = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q            <= IDLE;
         length_q           <= MIN_L;
         sin_mag_q          <= 8'd0;
         cos_mag_q          <= 8'd0;
         sin_neg_q          <= 1'b0;
         cos_neg_q          <= 1'b0;
         loaded_q           <= 1'b0;
         weight_q           <= 2'd0;
         delivered_q        <= 1'b0;
         delivered_weight_q <= 2'd0;
         swing_en_q         <= 1'b1;
         busy_q             <= 1'b0;
         tip_x_q            <= 11'(ORG_X);
         tip_y_q            <= 11'(REST_Y);
      end else begin
         state_q            <= state_d;
         length_q           <= length_d;
         if (latch_en) begin
            sin_mag_q <= sinMag;
            cos_mag_q <= cosMag;
            sin_neg_q <= sinNeg;
            cos_neg_q <= cosNeg;
         end
         loaded_q           <= loaded_d;
         weight_q           <= weight_d;
         delivered_q        <= (state_d == DELIVER);
         delivered_weight_q <= delivered_weight_d;
         swing_en_q         <= (state_d == IDLE);
         busy_q             <= (state_d != IDLE);
         tip_x_q            <= 11'(tip_x_d);
         tip_y_q            <= 11'(tip_y_d);
      end
   end

   assign tipX            = tip_x_q;
   assign tipY            = tip_y_q;
   assign swingEnable     = swing_en_q;
   assign busy            = busy_q;
   assign loaded          = loaded_q;
   assign delivered       = delivered_q;
   assign deliveredWeight = delivered_weight_q;
endmodule

// File: tb/tb_hook_reel.sv
// tb/tb_hook_reel.sv - self-checking bench for hook_reel with randomized launches and a behavioural model
module tb_hook_reel;
   logic        clk = 1'b0;
   logic        resetN, startOfFrame, fire, sinNeg, cosNeg, hit;
   logic [7:0]  sinMag, cosMag;
   logic [1:0]  hitWeight;
   logic [10:0] tipX, tipY;
   logic        swingEnable, busy, loaded, delivered;
   logic [1:0]  deliveredWeight;

   int checks = 0;
   int failures = 0;
   int n_deliv = 0;
   int mlen;
   int lv_sm, lv_sn, lv_cm, lv_cn;
   int l_sm, l_sn, l_cm, l_cn;
   logic [31:0] peak_y;

   hook_reel dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fire(fire),
      .sinMag(sinMag), .cosMag(cosMag), .sinNeg(sinNeg), .cosNeg(cosNeg),
      .hit(hit), .hitWeight(hitWeight), .tipX(tipX), .tipY(tipY),
      .swingEnable(swingEnable), .busy(busy), .loaded(loaded),
      .delivered(delivered), .deliveredWeight(deliveredWeight)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (delivered === 1'b1) n_deliv++;

   function automatic int model_x(int len, int cm, int cn);
      return (cn != 0) ? 320 - (len * cm) / 256 : 320 + (len * cm) / 256;
   endfunction

   function automatic int model_y(int len, int sm, int sn);
      return (sn != 0) ? 96 + (len * sm) / 256 : 96 - (len * sm) / 256;
   endfunction

   function automatic bit off_screen(int len, int sm, int sn, int cm, int cn);
      int x, y;
      x = model_x(len, cm, cn);
      y = model_y(len, sm, sn);
      return (x < 0) || (x >= 640) || (y < 0) || (y >= 480);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === 32'(exp)) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_tip(input string tag, input int len, input bit live);
      int sm, sn, cm, cn;
      if (live) begin sm = lv_sm; sn = lv_sn; cm = lv_cm; cn = lv_cn; end
      else      begin sm = l_sm;  sn = l_sn;  cm = l_cm;  cn = l_cn;  end
      check({tag, "_x"}, 32'(tipX), model_x(len, cm, cn) & 32'h7ff);
      check({tag, "_y"}, 32'(tipY), model_y(len, sm, sn) & 32'h7ff);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      step();
      repeat ($urandom_range(0, 2)) step();
   endtask

   task automatic set_live(input int sm, input int sn, input int cm, input int cn);
      lv_sm = sm; lv_sn = sn; lv_cm = cm; lv_cn = cn;
      sinMag = 8'(sm); sinNeg = sn[0]; cosMag = 8'(cm); cosNeg = cn[0];
   endtask

   task automatic launch();
      fire = 1'b1;
      step();
      l_sm = lv_sm; l_sn = lv_sn; l_cm = lv_cm; l_cn = lv_cn;
      check("launch_swing", 32'(swingEnable), 0);
      check("launch_busy", 32'(busy), 1);
   endtask

   // pull back until the step that lands on rest length, which is left pending with SOF high
   task automatic retract(input int rs);
      for (int f = 0; f < 700; f++) begin
         if (mlen - rs <= 100) break;
         mlen -= rs;
         frame();
         check_tip("ret", mlen, 1'b0);
      end
      mlen = 100;
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
   endtask

   task automatic run_empty(input bit hold_fire);
      int deliv0;
      launch();
      if (!hold_fire) begin
         fire = 1'b0;
         set_live($urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1));
      end
      mlen = 100;
      for (int f = 0; f < 160; f++) begin
         if (mlen + 4 > 600 || off_screen(mlen + 4, l_sm, l_sn, l_cm, l_cn)) break;
         mlen += 4;
         frame();
         check_tip("ext", mlen, 1'b0);
      end
      peak_y = 32'(tipY);
      frame();
      check_tip("edge", mlen, 1'b0);
      check("edge_busy", 32'(busy), 1);
      hitWeight = 2'd3;
      hit = 1'b1;
      step();
      hit = 1'b0;
      check("retract_hit_ignored", 32'(loaded), 0);
      deliv0 = n_deliv;
      retract(4);
      check("empty_done_swing", 32'(swingEnable), 1);
      check("empty_done_busy", 32'(busy), 0);
      step();
      check("empty_no_deliver", n_deliv, deliv0);
      if (hold_fire) begin
         l_sm = lv_sm; l_sn = lv_sn; l_cm = lv_cm; l_cn = lv_cn;
         check("relaunch_swing", 32'(swingEnable), 0);
         check("relaunch_busy", 32'(busy), 1);
      end else begin
         check_tip("idle_after", 100, 1'b1);
      end
   endtask

   task automatic run_grab(input int w, input int n_ext, input bit simul);
      int rs, deliv0;
      set_live(255, 1, 0, 0);
      step();
      launch();
      fire = 1'b0;
      mlen = 100;
      for (int f = 0; f < n_ext; f++) begin
         mlen += 4;
         frame();
         check_tip("gext", mlen, 1'b0);
      end
      hitWeight = 2'(w);
      hit = 1'b1;
      startOfFrame = simul;
      step();
      hit = 1'b0;
      startOfFrame = 1'b0;
      check("grab_loaded", 32'(loaded), 1);
      check_tip("grab_len", mlen, 1'b0);
      rs = 4;
`ifdef HOOK_REEL_WEIGHT_EN
      rs = ((4 >> w) < 1) ? 1 : (4 >> w);
`endif
      deliv0 = n_deliv;
      retract(rs);
      check("deliver_pulse", 32'(delivered), 1);
      check("deliver_weight", 32'(deliveredWeight), w);
      check("deliver_busy", 32'(busy), 1);
      step();
      check("deliver_end", 32'(delivered), 0);
      check("deliver_idle", 32'(swingEnable), 1);
      check("deliver_cleared", 32'(loaded), 0);
      check("deliver_hold_w", 32'(deliveredWeight), w);
      step();
      check("deliver_count", n_deliv, deliv0 + 1);
   endtask

   initial begin
      resetN = 1'b1;
      startOfFrame = 1'b0;
      fire = 1'b0;
      hit = 1'b0;
      hitWeight = 2'd0;
      set_live(255, 1, 0, 0);
      #1 resetN = 1'b0;
      #2;
      check("rst_tipx", 32'(tipX), 320);
      check("rst_tipy", 32'(tipY), 196);
      check("rst_swing", 32'(swingEnable), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_loaded", 32'(loaded), 0);
      check("rst_delivered", 32'(delivered), 0);
      check("rst_dweight", 32'(deliveredWeight), 0);
      step();
      step();
      resetN = 1'b1;
      step();
      check("first_idle_x", 32'(tipX), 320);
      check("first_idle_y", 32'(tipY), 195);

      for (int i = 0; i < 8; i++) begin
         set_live($urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1));
         hitWeight = 2'd2;
         hit = (i == 3);
         step();
         hit = 1'b0;
         check_tip("idle", 100, 1'b1);
         check("idle_swing", 32'(swingEnable), 1);
         check("idle_loaded", 32'(loaded), 0);
      end

      for (int r = 0; r < 4; r++) begin
         set_live($urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1));
         step();
         run_empty(1'b0);
      end

      set_live(32, 1, 16, 0);
      step();
      run_empty(1'b0);

      set_live(255, 1, 0, 0);
      step();
      run_empty(1'b1);
      check("peak_straight_down", peak_y, 478);

      mlen = 100;
      for (int f = 0; f < 15; f++) begin
         mlen += 4;
         frame();
      end
      check_tip("mid_extend", 160, 1'b0);
      fire = 1'b0;
      resetN = 1'b0;
      #2;
      check("mid_rst_tipx", 32'(tipX), 320);
      check("mid_rst_tipy", 32'(tipY), 196);
      check("mid_rst_swing", 32'(swingEnable), 1);
      check("mid_rst_busy", 32'(busy), 0);
      #2 resetN = 1'b1;
      step();
      check("after_rst_y", 32'(tipY), 195);

      run_grab(2, 25, 1'b0);
      run_grab(3, 71, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hook_reel.md
# hook_reel

Launch/retract controller for the miner's hook, and the consumer of the swinging hook's angle. While idle it tracks the live trig values from the rotation table and lets the swing run. On a fire request it freezes the swing and extends the hook along the latched ray, one step per frame. It then retracts empty or loaded, and reports the delivered object's weight to the scoring logic.

## Interface
- OFFSET_X, 320, pivot x in pixels
- OFFSET_Y, 96, pivot y in pixels
- MIN_LENGTH, 100, rest length of the hook
- MAX_LENGTH, 600, hard extension limit
- EXTEND_STEP, 4, length increment per frame while extending
- RETRACT_STEP, 4, length decrement per frame while retracting empty
- SCREEN_W, 640 and SCREEN_H, 480, visible area bounds
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle frame tick
- fire  in  1  launch request, level-sampled
- sinMag, cosMag  in  8 each  trig magnitudes, unsigned, 255 ≈ 1.0
- sinNeg, cosNeg  in  1 each  trig sign flags
- hit  in  1  collision of tip with an object
- hitWeight  in  2  weight of the colliding object, valid with hit
- tipX, tipY  out  11  registered hook tip position
- swingEnable  out  1  high only in IDLE; drives the swing's enable
- busy  out  1  high in EXTEND, RETRACT, DELIVER
- loaded  out  1  object attached
- delivered  out  1  one-cycle pulse when a loaded retract completes
- deliveredWeight  out  2  weight of the delivered object, held until next delivery

## Operation
- States: IDLE, EXTEND, RETRACT, DELIVER.
- Reset values: state IDLE, length=MIN_LENGTH, tipX=OFFSET_X, tipY=OFFSET_Y+MIN_LENGTH, swingEnable=1, busy=0, loaded=0, delivered=0, deliveredWeight=0. Latched trig resets to 0 with both signs 0.
- Tip arithmetic:
  - ox=(length·cosMag)>>8 and oy=(length·sinMag)>>8, with an 18-bit product and a 10-bit result.
  - tipX=OFFSET_X±ox, with minus when cosNeg.
  - tipY=OFFSET_Y+oy when sinNeg, else OFFSET_Y−oy.
  - Computed in 12-bit signed; output is the low 11 bits.
- IDLE: tip is recomputed every clk from the live trig inputs at MIN_LENGTH.
  - fire=1 → latch the four trig inputs and go to EXTEND.
- EXTEND: the tip uses the latched trig. On each startOfFrame, compute candidate length L'=length+EXTEND_STEP and its tip.
  - L'>MAX_LENGTH, or candidate x<0, x≥SCREEN_W, y<0 or y≥SCREEN_H → keep length and go to RETRACT empty.
  - Otherwise length=L'.
- hit=1 in EXTEND (any cycle) → latch hitWeight, set loaded=1, go to RETRACT. hit is ignored in all other states.
- Simultaneous hit and boundary on the same edge: hit wins.
- RETRACT: on each startOfFrame, length=max(MIN_LENGTH, length−step).
  - On reaching MIN_LENGTH: go to DELIVER if loaded, else to IDLE.
- DELIVER: one cycle. delivered=1, deliveredWeight=latched weight, loaded cleared, then IDLE.
- fire is ignored outside IDLE. Holding fire high relaunches on the first IDLE cycle.
- Reset mid-operation returns immediately to reset values; any partial grab is lost.

## Timing
- State, length and outputs are all registered.
- tip lags a length or trig change by one clk.
- swingEnable falls on the same edge that samples fire.
- Length changes only on startOfFrame edges, at most one step per frame.
- From retract completion to IDLE: two edges when loaded (via DELIVER), one edge when empty.

## Configuration
- HOOK_REEL_WEIGHT_EN defined: loaded retract step = max(1, RETRACT_STEP>>weight).
- HOOK_REEL_WEIGHT_EN undefined: retract step is always RETRACT_STEP. Weight is still latched and reported on deliveredWeight.

## Test plan
All scenarios use the default parameters. "Straight down" means sinMag=255, sinNeg=1, cosMag=0.

- Reset → tipX=320, tipY=196, swingEnable=1, busy=0. First IDLE clk with straight-down input → tipY=195.
- Empty boundary run:
  - Fire straight down → swingEnable=0 next edge. After 71 frames, length=384 and tipY=478.
  - The 72nd frame's candidate y=482 → RETRACT at length 384.
  - 71 frames later → IDLE, with no delivered pulse.
- Weighted grab:
  - Straight down, hit with hitWeight=2 at length 200 → loaded=1.
  - With macro: 100 frames to IDLE. Without macro: 25 frames.
  - Either way, delivered pulses one cycle and deliveredWeight=2.
- Simultaneous events: hit asserted on the same edge as a boundary detection → loaded=1 and weight latched.
- Ignored inputs: fire held high during EXTEND/RETRACT has no effect. hit in IDLE or RETRACT leaves loaded unchanged.
- Reset mid-operation: resetN low mid-EXTEND at length 160 → asynchronous return to reset values; tip=(320,196) without waiting for clk.
